calc_display: RTL and testbench
===============================

// Module: calc_display
// PURPOSE
//  Downstream of the calculator core. Captures the serial digit stream (wr_data
//  at wr_pos) the core emits during its print phase into a shadow buffer.
//  Commits the buffer atomically when the core reports ready.
//  Time-multiplexes the committed digits onto NDIG common-anode 7-segment displays.
// PARAMETERS
//  NDIG      8      number of display digits (buffer depth, anode width)
//  SCAN_DIV  50000  clocks per digit slot; >= 2
// PORTS
//  clock        in   1     system clock
//  reset        in   1     asynchronous, active-high
//  wr_data      in   4     digit value from core; 0-9 valid, 10-15 render blank
//  wr_pos       in   4     core print position; 1..NDIG = write slot wr_pos-1
//  calc_status  in   2     core status: 00 error, 01 busy, 10 ready, 11 reserved
//  an           out  NDIG  anode enables, active-low, one-hot-zero
//  seg          out  7     segments {g,f,e,d,c,b,a}, active-low
//  dp           out  1     decimal point, active-low, constant 1 (off)
// BEHAVIOUR
//  Reset: shadow and committed buffers all 4'hF (blank); prescaler 0; scan index 0;
//   an = all 1; seg = 7'h7F; dp = 1; status_q = 2'b10.
//  Capture, every clock:
//   - If 1 <= wr_pos <= NDIG, then shadow[wr_pos-1] <= wr_data.
//   - Otherwise (wr_pos = 0 or wr_pos > NDIG), ignore the write; no error.
//  Commit:
//   - status_q registers calc_status each clock.
//   - When calc_status == 10 and status_q != 10 (ready rising), committed <= shadow
//     in that same edge.
//   - A write and a commit on the same edge: commit takes the pre-write shadow.
//     The new write lands in shadow only.
//   - Writes while busy never change the display (no tearing).
//  Error mode, combinational on calc_status == 00:
//   - Digits 2,1,0 show 'E','r','r'; all other digits blank.
//   - Buffers keep updating.
//   - Leaving 00 restores the committed digits immediately.
//  Status 11: treated as busy.
//  Scan:
//   - Prescaler counts 0..SCAN_DIV-1, then wraps.
//   - On wrap, scan index advances; NDIG-1 wraps to 0.
//   - Each slot lasts exactly SCAN_DIV clocks.
//  Outputs registered:
//   - an[idx] = 0, all other bits 1.
//   - seg = decode of the selected digit.
//   - Output lags the scan index by 1 clock.
//   - Blanking interval: on the first clock of each slot, an = all 1 (anti-ghosting).
//  Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10,
//   E=06, r=2F, blank=7F.
//  Reset mid-scan or mid-capture: everything returns to reset values at once.
// CONFIGURATION
//  CALC_DISP_LZB_EN defined: leading-zero blanking.
//   - Any committed digit above the highest nonzero digit shows blank.
//   - Digit 0 is always shown ("0" for all-zero).
//   - Blank codes (10-15) count as zero.
//  Not defined: all committed digits are shown as stored.
//  Error mode is unaffected either way.
// STRUCTURE
//  Package calc_disp_pkg: status codes (ST_ERR, ST_BUSY, ST_READY), the SEG_*
//   7-bit segment constants, the BLANK code 4'hF.
//  Sub-module seg7_decode: combinational 4-bit + mode -> 7-bit active-low segments.
//  Top holds the buffers, commit logic, prescaler, scan and LZB logic.
// TESTING
//  1 Reset: after reset, check an=FF, seg=7F, dp=1; hold 20 clocks, outputs unchanged.
//  2 Commit: SCAN_DIV=4, status 01; write wr_pos 1..8 with data 1..8; status -> 10.
//    Digit k shows decode(k+1); each slot is 4 clocks; first clock of each slot is
//    blank; index wraps after 7.
//  3 Tearing: while committed, status 01; write 9 to pos 1.
//    Digit 0 keeps its old value until status returns to 10.
//  4 Error: status 00 -> digits 2..0 show 06,2F,2F, others 7F.
//    Status -> 10 -> the prior digits return.
//  5 Boundary: wr_pos 0 and 9..15 leave the buffer untouched; data 12 shows 7F.
//    Write at pos 3 on the same edge as ready: the commit excludes it.
//  6 LZB (macro on): commit {0,0,0,0,0,1,0,5} (digit7..0) -> digits 7..3 blank,
//    digits 2..0 show "105". All-zero -> only digit 0 shows "0".

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display path: core status codes, segment patterns
// (active-low {g,f,e,d,c,b,a}) and the decoder mode type.
package calc_disp_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  localparam logic [3:0] BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    DecDigit,
    DecE,
    DecR,
    DecBlank
  } dec_mode_e;

endpackage

// File: rtl/calc_display_seg7_decode.sv
// Combinational 7-segment decoder: digit value plus render mode to active-low segments.
// Values 10-15 in digit mode render blank.
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] value_i,
  input  dec_mode_e  mode_i,
  output logic [6:0] seg_o
);

  logic [6:0] digit_seg;

  always_comb begin
    digit_seg = SEG_BLANK;
    unique case (value_i)
      4'd0:    digit_seg = SEG_0;
      4'd1:    digit_seg = SEG_1;
      4'd2:    digit_seg = SEG_2;
      4'd3:    digit_seg = SEG_3;
      4'd4:    digit_seg = SEG_4;
      4'd5:    digit_seg = SEG_5;
      4'd6:    digit_seg = SEG_6;
      4'd7:    digit_seg = SEG_7;
      4'd8:    digit_seg = SEG_8;
      4'd9:    digit_seg = SEG_9;
      default: digit_seg = SEG_BLANK;
    endcase
  end

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (mode_i)
      DecDigit: seg_o = digit_seg;
      DecE:     seg_o = SEG_E;
      DecR:     seg_o = SEG_R;
      DecBlank: seg_o = SEG_BLANK;
      default:  seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Display back end for the calculator core: shadow capture, atomic commit on ready, and a
// multiplexed NDIG-digit scan. Define CALC_DISP_LZB_EN to enable leading-zero blanking.
module calc_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      wr_data,
  input  logic [3:0]      wr_pos,
  input  logic [1:0]      calc_status,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam int unsigned IdxW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PrescW = $clog2(SCAN_DIV);

  logic [NDIG-1:0][3:0] shadow_q, shadow_d;
  logic [NDIG-1:0][3:0] committed_q, committed_d;
  logic [1:0]           status_q;
  logic [PrescW-1:0]    presc_q, presc_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NDIG-1:0]      an_q, an_d;
  logic [6:0]           seg_q, seg_d;

  logic                 commit;
  logic                 presc_wrap;
  logic [NDIG-1:0]      keep;
  logic [3:0]           sel_val;
  dec_mode_e            sel_mode;

  // Commit samples the shadow before this edge's write, so a same-edge write lands later.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (int'(wr_pos) == i + 1) shadow_d[i] = wr_data;
    end
    commit      = (calc_status == ST_READY) && (status_q != ST_READY);
    committed_d = commit ? shadow_q : committed_q;
  end

  always_comb begin
    presc_wrap = (presc_q == PrescW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
  end

`ifdef CALC_DISP_LZB_EN
  // keep[k] is set when some digit at or above k is nonzero; blank codes count as zero.
  always_comb begin
    keep = '0;
    keep[NDIG-1] = committed_q[NDIG-1] inside {[4'd1:4'd9]};
    for (int i = int'(NDIG) - 2; i >= 0; i--) begin
      keep[i] = keep[i+1] | (committed_q[i] inside {[4'd1:4'd9]});
    end
    keep[0] = 1'b1;
  end
`else
  always_comb begin
    keep = '1;
  end
`endif

  always_comb begin
    sel_val  = committed_q[idx_q];
    sel_mode = DecDigit;
    if (calc_status == ST_ERR) begin
      if (idx_q == IdxW'(2)) begin
        sel_mode = DecE;
      end else if (idx_q == IdxW'(1) || idx_q == IdxW'(0)) begin
        sel_mode = DecR;
      end else begin
        sel_mode = DecBlank;
      end
    end else if (!keep[idx_q]) begin
      sel_mode = DecBlank;
    end
  end

  seg7_decode u_seg7_decode (
    .value_i (sel_val),
    .mode_i  (sel_mode),
    .seg_o   (seg_d)
  );

  // First clock of every slot keeps all anodes off to avoid ghosting between digits.
  always_comb begin
    an_d = '1;
    if (presc_q != '0) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        an_d[i] = (idx_q != IdxW'(i));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q    <= {NDIG{BLANK}};
      committed_q <= {NDIG{BLANK}};
      status_q    <= ST_READY;
      presc_q     <= '0;
      idx_q       <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      shadow_q    <= shadow_d;
      committed_q <= committed_d;
      status_q    <= calc_status;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Directed self-checking bench for calc_display with NDIG=8, SCAN_DIV=4.
module tb_calc_display;

  localparam int unsigned NDIG     = 8;
  localparam int unsigned SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] wr_data = 4'd0;
  logic [3:0] wr_pos = 4'd0;
  logic [1:0] calc_status = 2'b10;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  calc_display #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_pos      (wr_pos),
    .calc_status (calc_status),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic put(input int pos, input int data);
    wr_pos  = 4'(pos);
    wr_data = 4'(data);
    tick(1);
    wr_pos  = 4'd0;
    wr_data = 4'd0;
  endtask

  task automatic set_status(input logic [1:0] st);
    calc_status = st;
    tick(1);
  endtask

  task automatic check_digit(input int k, input logic [6:0] exp, input string tag);
    logic [7:0] target;
    bit found;
    target = ~(8'b1 << k);
    found  = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      tick(1);
      if (an === target) found = 1'b1;
    end
    if (!found) check_eq({tag, " timeout"}, {24'd0, an}, {24'd0, target});
    else check_eq(tag, {25'd0, seg}, {25'd0, exp});
  endtask

  task automatic check_all(input logic [7:0][6:0] exp, input string tag);
    for (int k = 0; k < 8; k++) begin
      check_digit(k, exp[k], $sformatf("%s d%0d", tag, k));
    end
  endtask

  initial begin
    logic [7:0] prev;
    bit synced;

    // Reset held: outputs must stay at reset values.
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (c % 5 == 0) begin
        check_eq($sformatf("reset_an c%0d", c), {24'd0, an}, 32'hFF);
        check_eq($sformatf("reset_seg c%0d", c), {25'd0, seg}, 32'h7F);
        check_eq($sformatf("reset_dp c%0d", c), {31'd0, dp}, 32'd1);
      end
    end
    reset = 1'b0;
    tick(3);
    check_eq("post_reset_seg_blank", {25'd0, seg}, 32'h7F);

    // Commit 1..8 into digits 0..7.
    set_status(2'b01);
    for (int p = 1; p <= 8; p++) put(p, p);
    set_status(2'b10);
    tick(2);

    prev   = 8'hFF;
    synced = 1'b0;
    for (int c = 0; c < 200 && !synced; c++) begin
      tick(1);
      if (prev == 8'hFF && an == 8'hFE) synced = 1'b1;
      else prev = an;
    end
    check_eq("scan_sync", {31'd0, synced}, 32'd1);
    if (synced) begin
      for (int t = 0; t < 36; t++) begin
        int slot;
        slot = (t / 4) % 8;
        if (t % 4 == 3) begin
          check_eq($sformatf("scan_an t%0d", t), {24'd0, an}, 32'hFF);
        end else begin
          check_eq($sformatf("scan_an t%0d", t), {24'd0, an}, {24'd0, ~(8'b1 << slot)});
          check_eq($sformatf("scan_seg t%0d", t), {25'd0, seg}, {25'd0, seg_of(slot + 1)});
        end
        tick(1);
      end
    end

    // No tearing: busy write stays hidden until ready.
    set_status(2'b01);
    put(1, 9);
    tick(2);
    check_digit(0, seg_of(1), "tear_hold");
    check_digit(1, seg_of(2), "tear_hold_d1");
    set_status(2'b10);
    tick(2);
    check_digit(0, seg_of(9), "tear_commit");

    // Error overlay and restore.
    set_status(2'b00);
    tick(2);
    check_all({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F}, "err");
    set_status(2'b10);
    tick(2);
    check_all({seg_of(8), seg_of(7), seg_of(6), seg_of(5), seg_of(4), seg_of(3), seg_of(2),
               seg_of(9)}, "err_exit");

    // Out-of-range positions ignored; code 12 renders blank.
    set_status(2'b01);
    put(0, 0);
    for (int p = 9; p <= 15; p++) put(p, 0);
    put(2, 12);
    set_status(2'b10);
    tick(2);
    check_all({seg_of(8), seg_of(7), seg_of(6), seg_of(5), seg_of(4), seg_of(3), 7'h7F,
               seg_of(9)}, "bound");

    // Write on the commit edge goes to shadow only.
    set_status(2'b01);
    calc_status = 2'b10;
    wr_pos      = 4'd3;
    wr_data     = 4'd0;
    tick(1);
    wr_pos = 4'd0;
    tick(2);
    check_digit(2, seg_of(3), "same_edge_excl");
    set_status(2'b01);
    set_status(2'b10);
    tick(2);
    check_digit(2, seg_of(0), "same_edge_later");

`ifdef CALC_DISP_LZB_EN
    set_status(2'b01);
    put(1, 5);
    put(2, 0);
    put(3, 1);
    for (int p = 4; p <= 8; p++) put(p, 0);
    set_status(2'b10);
    tick(2);
    check_all({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}, "lzb_105");
    set_status(2'b01);
    put(1, 0);
    put(3, 0);
    set_status(2'b10);
    tick(2);
    check_all({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "lzb_zero");
`endif

    // Asynchronous reset mid-scan.
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_eq("async_reset_an", {24'd0, an}, 32'hFF);
    check_eq("async_reset_seg", {25'd0, seg}, 32'h7F);
    tick(2);
    reset = 1'b0;
    tick(3);
    check_digit(0, 7'h7F, "reset_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
